pwm_sequencer: RTL and testbench
================================

// Module: pwm_sequencer
// PURPOSE
//  Command scheduler in front of the two-phase PWM drive engine. Software queues
//  {period, cycles} move commands over Avalon-MM. The block issues them one at a time
//  to the engine via a start/done handshake, inserts a fixed gap between moves, and
//  raises irq when the queue drains. It sits between the Nios Avalon fabric and the engine.
// PARAMETERS
//  FIFO_DEPTH   4   command queue entries; power of two, 2..16
//  GAP_CYCLES   16  idle clocks between engine done and next cmd_start; 0 = no gap
//  ARM_TIMEOUT  8   max clocks for drv_done to fall after cmd_start
// PORTS
//  a_50_MHZ_CLK in   1   system clock
//  reset_n      in   1   reset, asynchronous, active-low
//  address      in   2   Avalon word address
//  chipselect   in   1   Avalon select
//  write_n      in   1   Avalon write strobe, active-low
//  writedata    in   32  Avalon write data
//  readdata     out  32  Avalon read data, registered
//  irq          out  1   level interrupt = irq_pend & irq_en
//  cmd_period   out  32  period to engine; held stable from cmd_start until drv_done rises
//  cmd_cycles   out  8   cycle count to engine; same hold rule
//  cmd_start    out  1   one-clock pulse: engine loads cmd_*
//  drv_abort    out  1   one-clock pulse: engine forces idle
//  drv_done     in   1   engine idle level (1 = idle)
// BEHAVIOUR
//  Reset (async): all outputs 0; FIFO empty; state S_IDLE; ctrl and sticky flags 0.
//  Registers:
//   addr0 RW  period staging [31:0]
//   addr1 W   [7:0] cycles; a write pushes {staging, cycles}. Reads 0.
//   addr2 RW  [0] enable, [1] irq_en, [2] abort (write 1 = pulse, reads 0)
//   addr3 R   [4:0] count, [8] empty, [9] full, [10] busy,
//             [11] overflow, [12] timeout, [13] irq_pend
//             write 1 to bits 11..13 clears them (W1C)
//  readdata: registered mux of address every clock, so 1-clock read latency.
//  Push while full is dropped and sets overflow. A push and pop in the same clock when full
//   is accepted; count is unchanged.
//  FSM (busy = state != S_IDLE):
//   S_IDLE  : enable & !empty -> pop head into cmd_* regs.
//             If cycles==0, discard the entry and stay in S_IDLE; otherwise go to S_ISSUE.
//   S_ISSUE : cmd_start=1 for 1 clock -> S_ARM; load timeout counter.
//   S_ARM   : drv_done==0 -> S_RUN. Counter reaches ARM_TIMEOUT -> set timeout, pulse
//             drv_abort, go to S_IDLE.
//   S_RUN   : drv_done==1 -> S_GAP (load gap counter), or S_IDLE if GAP_CYCLES==0.
//   S_GAP   : count GAP_CYCLES clocks -> S_IDLE.
//  irq_pend sets on the clock the FSM enters S_IDLE from S_RUN/S_GAP with the FIFO empty.
//  Abort, from any state: flush FIFO, drv_abort=1 for 1 clock, go to S_IDLE, clear enable.
//   Abort has priority over a simultaneous push, which is dropped without setting overflow.
//  enable=0 mid-move: the current move completes; no further pops.
//  count width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//  Package pwm_seq_pkg: state encoding localparams (S_IDLE..S_GAP), register address
//   constants, status bit indices.
//  Sub-module pwm_cmd_fifo: 40-bit wide, synchronous FIFO with count/full/empty and a
//   flush input. Read is first-word-fall-through.
//  The top holds the Avalon decode, the FSM, the timeout/gap counters and irq.
// TESTING
//  1 push {1000,4}, enable=1, model drops done 2 clks after start and raises it 50 clks
//    later -> exactly one cmd_start; cmd_period=1000, cmd_cycles=4; 16-clk gap; irq=0 while
//    irq_en=0, then irq_pend=1.
//  2 push 5 entries with FIFO_DEPTH=4, enable=0 -> count=4, full=1, overflow=1; W1C 0x800
//    clears overflow.
//  3 queue {10,3},{20,0},{30,2} -> cmd_start pulses only for 10 and 30; the cycles=0 entry
//    is skipped.
//  4 drv_done held at 1 after cmd_start -> after 8 clks timeout=1, one drv_abort pulse,
//    busy=0.
//  5 abort written during S_RUN with 3 entries queued -> drv_abort pulse, count=0,
//    enable=0, no further cmd_start.
//  6 reset_n low mid-S_GAP -> all outputs 0 at once; after release status reads 0x100.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM command sequencer: FSM encoding, register map,
// status bit positions and the queued command layout.
package pwm_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_ARM   = 3'd2;
  localparam state_t S_RUN   = 3'd3;
  localparam state_t S_GAP   = 3'd4;

  localparam logic [1:0] ADDR_STAGE  = 2'd0;
  localparam logic [1:0] ADDR_PUSH   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int ST_EMPTY    = 8;
  localparam int ST_FULL     = 9;
  localparam int ST_BUSY     = 10;
  localparam int ST_OVERFLOW = 11;
  localparam int ST_TIMEOUT  = 12;
  localparam int ST_IRQ_PEND = 13;

  typedef struct packed {
    logic [31:0] period;
    logic [7:0]  cycles;
  } cmd_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// Avalon-MM slave port bundle between the Nios fabric and the sequencer.
interface pwm_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/pwm_cmd_fifo.sv
// Command queue: power-of-two deep, first-word-fall-through, with a flush that
// wins over a simultaneous push or pop.
module pwm_cmd_fifo
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     a_50_MHZ_CLK,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = cnt_width(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  cmd_t           mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [PW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // A push into a full queue still lands when the head leaves in the same clock.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge a_50_MHZ_CLK) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// Avalon-MM command scheduler that feeds queued {period, cycles} moves to the
// PWM drive engine one at a time, with an inter-move gap and a drain interrupt.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic               a_50_MHZ_CLK,
  input  logic               reset_n,
  pwm_sequencer_if.slave     bus,
  output logic               irq,
  output logic [31:0]        cmd_period,
  output logic [7:0]         cmd_cycles,
  output logic               cmd_start,
  output logic               drv_abort,
  input  logic               drv_done
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int ARM_W = cnt_width(ARM_TIMEOUT);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic [31:0]       staging_reg;
  logic              enable_reg, irq_en_reg;
  logic              overflow_reg, timeout_reg, irq_pend_reg;
  logic              drv_abort_reg;
  logic [31:0]       cmd_period_reg;
  logic [7:0]        cmd_cycles_reg;
  logic [ARM_W-1:0]  arm_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;

  logic              wr_en, wr_stage, wr_push, wr_ctrl, wr_status;
  logic              abort_req, overflow_evt;
  logic [31:0]       w1c;
  logic              pop, load_cmd, arm_expire, drained;
  cmd_t              head;
  cmd_t              push_data;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic [31:0]       status_word, rd_mux;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wr_stage  = wr_en && (bus.address == ADDR_STAGE);
  assign wr_push   = wr_en && (bus.address == ADDR_PUSH);
  assign wr_ctrl   = wr_en && (bus.address == ADDR_CTRL);
  assign wr_status = wr_en && (bus.address == ADDR_STATUS);
  assign abort_req = wr_ctrl && bus.writedata[CTRL_ABORT];
  assign w1c       = wr_status ? bus.writedata : 32'd0;

  // An abort flushes the queue, so a push in the same clock is silently lost.
  assign overflow_evt = wr_push && fifo_full && !pop && !abort_req;
  assign push_data    = '{period: staging_reg, cycles: bus.writedata[7:0]};

  pwm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .a_50_MHZ_CLK (a_50_MHZ_CLK),
    .reset_n      (reset_n),
    .flush        (abort_req),
    .push         (wr_push),
    .push_data    (push_data),
    .pop          (pop),
    .head         (head),
    .count        (fifo_count),
    .empty        (fifo_empty),
    .full         (fifo_full)
  );

  always_ff @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort_req) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (enable_reg && !fifo_empty && (head.cycles != 8'd0)) state_next = S_ISSUE;
        S_ISSUE: state_next = S_ARM;
        S_ARM: begin
          if (!drv_done)                     state_next = S_RUN;
          else if (arm_cnt_reg == ARM_LAST)  state_next = S_IDLE;
        end
        S_RUN:   if (drv_done) state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        S_GAP:   if (gap_cnt_reg == GAP_LAST) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pop        = 1'b0;
    load_cmd   = 1'b0;
    arm_expire = 1'b0;
    cmd_start  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Zero-cycle entries are popped and dropped without touching cmd_*.
        pop      = enable_reg && !fifo_empty && !abort_req;
        load_cmd = pop && (head.cycles != 8'd0);
      end
      S_ISSUE: cmd_start = 1'b1;
      S_ARM:   arm_expire = drv_done && (arm_cnt_reg == ARM_LAST) && !abort_req;
      default: ;
    endcase
    drained = ((state_reg == S_RUN) || (state_reg == S_GAP)) && (state_next == S_IDLE)
              && !abort_req && fifo_empty;
  end

  always_comb begin
    status_word = 32'd0;
    status_word[CW-1:0]      = fifo_count;
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[ST_FULL]     = fifo_full;
    status_word[ST_BUSY]     = (state_reg != S_IDLE);
    status_word[ST_OVERFLOW] = overflow_reg;
    status_word[ST_TIMEOUT]  = timeout_reg;
    status_word[ST_IRQ_PEND] = irq_pend_reg;
    case (bus.address)
      ADDR_STAGE: rd_mux = staging_reg;
      ADDR_CTRL:  rd_mux = {30'd0, irq_en_reg, enable_reg};
      ADDR_STATUS: rd_mux = status_word;
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) begin
      staging_reg    <= 32'd0;
      enable_reg     <= 1'b0;
      irq_en_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
      timeout_reg    <= 1'b0;
      irq_pend_reg   <= 1'b0;
      drv_abort_reg  <= 1'b0;
      cmd_period_reg <= 32'd0;
      cmd_cycles_reg <= 8'd0;
      arm_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      bus.readdata   <= 32'd0;
    end else begin
      if (wr_stage) staging_reg <= bus.writedata;
      if (abort_req)    enable_reg <= 1'b0;
      else if (wr_ctrl) enable_reg <= bus.writedata[CTRL_ENABLE];
      if (wr_ctrl)      irq_en_reg <= bus.writedata[CTRL_IRQ_EN];
      if (load_cmd) begin
        cmd_period_reg <= head.period;
        cmd_cycles_reg <= head.cycles;
      end
      // Both counters sit at zero outside their state, so entry needs no explicit load.
      arm_cnt_reg   <= (state_reg == S_ARM) ? arm_cnt_reg + 1'b1 : '0;
      gap_cnt_reg   <= (state_reg == S_GAP) ? gap_cnt_reg + 1'b1 : '0;
      drv_abort_reg <= abort_req || arm_expire;
      overflow_reg  <= overflow_evt || (overflow_reg && !w1c[ST_OVERFLOW]);
      timeout_reg   <= arm_expire   || (timeout_reg  && !w1c[ST_TIMEOUT]);
      irq_pend_reg  <= drained      || (irq_pend_reg && !w1c[ST_IRQ_PEND]);
      bus.readdata  <= rd_mux;
    end
  end

  assign irq        = irq_pend_reg && irq_en_reg;
  assign drv_abort  = drv_abort_reg;
  assign cmd_period = cmd_period_reg;
  assign cmd_cycles = cmd_cycles_reg;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: Avalon register traffic against a small
// engine model that answers cmd_start by dropping and later raising drv_done.
module tb_pwm_sequencer;
  import pwm_seq_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int GAP_CYCLES  = 16;
  localparam int ARM_TIMEOUT = 8;

  logic        a_50_MHZ_CLK = 1'b0;
  logic        reset_n      = 1'b0;
  logic        irq;
  logic [31:0] cmd_period;
  logic [7:0]  cmd_cycles;
  logic        cmd_start;
  logic        drv_abort;
  logic        drv_done;
  logic        stuck = 1'b0;

  pwm_sequencer_if bus ();

  pwm_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .GAP_CYCLES  (GAP_CYCLES),
    .ARM_TIMEOUT (ARM_TIMEOUT)
  ) dut (
    .a_50_MHZ_CLK (a_50_MHZ_CLK),
    .reset_n      (reset_n),
    .bus          (bus),
    .irq          (irq),
    .cmd_period   (cmd_period),
    .cmd_cycles   (cmd_cycles),
    .cmd_start    (cmd_start),
    .drv_abort    (drv_abort),
    .drv_done     (drv_done)
  );

  always #10 a_50_MHZ_CLK = ~a_50_MHZ_CLK;

  int cyc = 0;
  always @(posedge a_50_MHZ_CLK) cyc <= cyc + 1;

  // Engine: busy from two clocks after cmd_start for 50 clocks; stuck keeps it idle.
  int eng_cnt;
  always @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) begin
      drv_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (drv_abort) begin
      drv_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (cmd_start && !stuck) begin
      eng_cnt <= 1;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 2) drv_done <= 1'b0;
      if (eng_cnt == 52) begin
        drv_done <= 1'b1;
        eng_cnt  <= 0;
      end
    end
  end

  logic [31:0] start_period [64];
  logic [7:0]  start_cycles [64];
  int start_count = 0, start_cyc = 0, abort_count = 0, abort_cyc = 0;
  always @(negedge a_50_MHZ_CLK) begin
    if (cmd_start && start_count < 64) begin
      start_period[start_count] <= cmd_period;
      start_cycles[start_count] <= cmd_cycles;
      start_cyc   <= cyc;
      start_count <= start_count + 1;
    end
    if (drv_abort) begin
      abort_cyc   <= cyc;
      abort_count <= abort_count + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge a_50_MHZ_CLK);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic push_cmd(input logic [31:0] period, input logic [7:0] cycles);
    reg_write(ADDR_STAGE, period);
    reg_write(ADDR_PUSH, {24'd0, cycles});
  endtask

  task automatic wait_idle(input int bound, input string tag);
    logic [31:0] s;
    s = 32'h400;
    for (int i = 0; i < bound; i++) begin
      reg_read(ADDR_STATUS, s);
      if (!s[ST_BUSY] && s[ST_EMPTY]) break;
    end
    check(tag, {31'd0, s[ST_BUSY]}, 32'd0);
  endtask

  task automatic wait_done(input logic lvl, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      if (drv_done == lvl) break;
      tick();
    end
    check(tag, {31'd0, drv_done}, {31'd0, lvl});
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int base, abase, d_cyc, b_cyc;
    bit seen_low;

    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    repeat (3) tick();
    check("rst cmd_start",  {31'd0, cmd_start}, 32'd0);
    check("rst drv_abort",  {31'd0, drv_abort}, 32'd0);
    check("rst irq",        {31'd0, irq}, 32'd0);
    check("rst cmd_period", cmd_period, 32'd0);
    check("rst cmd_cycles", {24'd0, cmd_cycles}, 32'd0);
    check("rst readdata",   bus.readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    reg_read(ADDR_STATUS, rd);
    check("rst status", rd, 32'h100);

    // 1: single move; busy drops GAP_CYCLES+2 clocks after drv_done rises
    //    (one clock for the FSM to see done, the gap, one clock of readdata latency).
    push_cmd(32'd1000, 8'd4);
    reg_write(ADDR_CTRL, 32'h1);
    bus.address = ADDR_STATUS;
    d_cyc = -1; b_cyc = -1; seen_low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!drv_done) seen_low = 1;
      else if (seen_low && d_cyc < 0) d_cyc = cyc;
      if (d_cyc >= 0 && !bus.readdata[ST_BUSY]) begin
        b_cyc = cyc;
        break;
      end
    end
    check("t1 gap clocks", b_cyc - d_cyc, GAP_CYCLES + 2);
    check("t1 start count", start_count, 1);
    check("t1 cmd_period", start_period[0], 32'd1000);
    check("t1 cmd_cycles", {24'd0, start_cycles[0]}, 32'd4);
    check("t1 irq masked", {31'd0, irq}, 32'd0);
    reg_read(ADDR_STATUS, rd);
    check("t1 status irq_pend", rd, 32'h2100);
    reg_write(ADDR_CTRL, 32'h3);
    check("t1 irq enabled", {31'd0, irq}, 32'd1);
    reg_write(ADDR_STATUS, 32'h2000);
    check("t1 irq cleared", {31'd0, irq}, 32'd0);
    reg_write(ADDR_CTRL, 32'h0);

    // 2: overflow on a disabled, full queue
    for (int i = 0; i < 5; i++) push_cmd(32'd500 + i, 8'd1);
    reg_read(ADDR_STATUS, rd);
    check("t2 full+overflow", rd, 32'hA04);
    reg_write(ADDR_STATUS, 32'h800);
    reg_read(ADDR_STATUS, rd);
    check("t2 overflow w1c", rd, 32'h204);
    reg_write(ADDR_CTRL, 32'h4);
    reg_read(ADDR_STATUS, rd);
    check("t2 flushed", rd, 32'h100);

    // 3: zero-cycle entry is skipped
    base = start_count;
    push_cmd(32'd10, 8'd3);
    push_cmd(32'd20, 8'd0);
    push_cmd(32'd30, 8'd2);
    reg_write(ADDR_CTRL, 32'h1);
    wait_idle(600, "t3 idle");
    check("t3 start count", start_count - base, 2);
    check("t3 first period", start_period[base], 32'd10);
    check("t3 first cycles", {24'd0, start_cycles[base]}, 32'd3);
    check("t3 second period", start_period[base + 1], 32'd30);
    check("t3 second cycles", {24'd0, start_cycles[base + 1]}, 32'd2);
    reg_read(ADDR_STATUS, rd);
    check("t3 status", rd, 32'h2100);
    reg_write(ADDR_STATUS, 32'h2000);

    // 4: engine never leaves idle; abort lands ARM_TIMEOUT clocks in ARM plus one register stage
    stuck = 1'b1;
    abase = abort_count;
    push_cmd(32'd40, 8'd1);
    for (int i = 0; i < 40; i++) begin
      if (abort_count != abase) break;
      tick();
    end
    check("t4 abort latency", abort_cyc - start_cyc, ARM_TIMEOUT + 1);
    repeat (4) tick();
    check("t4 abort pulses", abort_count - abase, 1);
    reg_read(ADDR_STATUS, rd);
    check("t4 status timeout", rd, 32'h1100);
    reg_write(ADDR_STATUS, 32'h1000);
    stuck = 1'b0;

    // 5: abort mid-run with three entries queued
    base  = start_count;
    push_cmd(32'd100, 8'd5);
    push_cmd(32'd110, 8'd1);
    push_cmd(32'd120, 8'd1);
    push_cmd(32'd130, 8'd1);
    wait_done(1'b0, 30, "t5 engine running");
    reg_read(ADDR_STATUS, rd);
    check("t5 status queued", rd, 32'h403);
    abase = abort_count;
    reg_write(ADDR_CTRL, 32'h4);
    repeat (2) tick();
    check("t5 abort pulses", abort_count - abase, 1);
    reg_read(ADDR_STATUS, rd);
    check("t5 status flushed", rd, 32'h100);
    reg_read(ADDR_CTRL, rd);
    check("t5 enable cleared", rd, 32'h0);
    repeat (100) tick();
    check("t5 start count", start_count - base, 1);

    // 6: asynchronous reset while in the gap
    reg_write(ADDR_CTRL, 32'h1);
    push_cmd(32'd200, 8'd1);
    wait_done(1'b0, 30, "t6 engine running");
    wait_done(1'b1, 100, "t6 engine done");
    repeat (3) tick();
    reg_read(ADDR_STATUS, rd);
    check("t6 busy in gap", rd, 32'h500);
    check("t6 period held", cmd_period, 32'd200);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6 cmd_period", cmd_period, 32'd0);
    check("t6 cmd_cycles", {24'd0, cmd_cycles}, 32'd0);
    check("t6 cmd_start",  {31'd0, cmd_start}, 32'd0);
    check("t6 drv_abort",  {31'd0, drv_abort}, 32'd0);
    check("t6 irq",        {31'd0, irq}, 32'd0);
    check("t6 readdata",   bus.readdata, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    reg_read(ADDR_STATUS, rd);
    check("t6 status", rd, 32'h100);
    reg_read(ADDR_CTRL, rd);
    check("t6 ctrl", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
